// File: rtl/tank_sprite_line_fetcher_if.sv
// Bundle of video timing, sprite attributes, sprite ROM and pixel output signals
// for the tank sprite line fetcher.
interface tank_sprite_line_fetcher_if;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        line_start;
    logic [9:0]  tank_x;
    logic [9:0]  tank_y;
    logic [1:0]  tank_dir;
    logic        tank_en;
    logic [11:0] rom_address;
    logic        rom_clken;
    logic [7:0]  rom_readdata;
    logic        busy;
    logic        pixel_valid;
    logic [7:0]  pixel_color;

    modport slave (
        input  hcount, vcount, line_start, tank_x, tank_y, tank_dir, tank_en, rom_readdata,
        output rom_address, rom_clken, busy, pixel_valid, pixel_color
    );

    modport master (
        output hcount, vcount, line_start, tank_x, tank_y, tank_dir, tank_en, rom_readdata,
        input  rom_address, rom_clken, busy, pixel_valid, pixel_color
    );
endinterface

// File: rtl/tank_sprite_line_fetcher.sv
// Fetches the next scanline's rotated tank sprite row into a 64-byte buffer during
// horizontal blank and emits buffered pixels as registered colour indices.
module tank_sprite_line_fetcher #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_TOTAL     = 525,
    parameter logic [7:0]  TRANSPARENT = 8'h00
) (
    input logic                         clk,
    input logic                         reset_n,
    tank_sprite_line_fetcher_if.slave   bus_io
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StFetch = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [5:0]  col_q, col_d;
    logic [5:0]  row_q, row_d;
    logic        line_ok_q, line_ok_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [1:0]  dir_q, dir_d;
    logic        en_q, en_d;
    logic [11:0] rom_addr_q, rom_addr_d;
    logic        rom_clken_q, busy_q;
    logic        pix_valid_q, pix_valid_d;
    logic [7:0]  pix_color_q, pix_color_d;
    logic [7:0]  line_buf_q [64];

    logic        buf_we;
    logic [5:0]  buf_idx;
    logic        last_line, latch_now, in_sprite;
    logic [9:0]  next_line, row_full, hoff;
    logic [7:0]  buf_pix;

    // Rotation is realised purely by remapping the ROM address; ~v equals 63-v on 6 bits.
    function automatic logic [11:0] map_addr(input logic [1:0] dir, input logic [5:0] r,
                                             input logic [5:0] c);
        case (dir)
            2'd0:    map_addr = {r, c};
            2'd1:    map_addr = {~c, r};
            2'd2:    map_addr = {~r, ~c};
            default: map_addr = {c, ~r};
        endcase
    endfunction

    // Attributes are latched only at the hblank preceding line 0 so a frame never tears.
    assign last_line = (bus_io.vcount == 10'(V_TOTAL - 1));
    assign latch_now = bus_io.line_start && last_line;
    assign x_d       = latch_now ? bus_io.tank_x   : x_q;
    assign y_d       = latch_now ? bus_io.tank_y   : y_q;
    assign dir_d     = latch_now ? bus_io.tank_dir : dir_q;
    assign en_d      = latch_now ? bus_io.tank_en  : en_q;

    assign next_line = last_line ? 10'd0 : bus_io.vcount + 10'd1;
    assign row_full  = next_line - y_d;
    assign in_sprite = en_d && (next_line >= y_d) && (row_full < 10'd64);

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        line_ok_d = line_ok_q;
        buf_we    = 1'b0;
        buf_idx   = col_q - 6'd1;
        if (bus_io.line_start) begin
            // A new line_start always wins: any fetch in flight is abandoned unwritten.
            if (state_q != StIdle) begin
                line_ok_d = 1'b0;
            end
            if (in_sprite) begin
                state_d = StFetch;
                col_d   = '0;
                row_d   = row_full[5:0];
            end else begin
                state_d   = StIdle;
                line_ok_d = 1'b0;
            end
        end else begin
            case (state_q)
                StFetch: begin
                    buf_we = (col_q != 6'd0);
                    if (col_q == 6'd63) begin
                        state_d = StDrain;
                    end else begin
                        col_d = col_q + 6'd1;
                    end
                end
                StDrain: begin
                    buf_we    = 1'b1;
                    buf_idx   = 6'd63;
                    line_ok_d = 1'b1;
                    state_d   = StIdle;
                end
                default: ;
            endcase
        end
    end

    assign rom_addr_d = (state_d == StFetch) ? map_addr(dir_d, row_d, col_d) : rom_addr_q;

    assign hoff    = bus_io.hcount - x_q;
    assign buf_pix = line_buf_q[hoff[5:0]];

    always_comb begin
        pix_valid_d = line_ok_q && (bus_io.hcount < 10'(H_ACTIVE)) && (bus_io.hcount >= x_q) &&
                      (hoff < 10'd64) && (buf_pix != TRANSPARENT);
        pix_color_d = pix_valid_d ? buf_pix : 8'h00;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            col_q       <= '0;
            row_q       <= '0;
            line_ok_q   <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            dir_q       <= '0;
            en_q        <= 1'b0;
            rom_addr_q  <= '0;
            rom_clken_q <= 1'b0;
            busy_q      <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_color_q <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            line_ok_q   <= line_ok_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dir_q       <= dir_d;
            en_q        <= en_d;
            rom_addr_q  <= rom_addr_d;
            rom_clken_q <= (state_d == StFetch);
            busy_q      <= (state_d != StIdle);
            pix_valid_q <= pix_valid_d;
            pix_color_q <= pix_color_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            line_buf_q[buf_idx] <= bus_io.rom_readdata;
        end
    end

    assign bus_io.rom_address = rom_addr_q;
    assign bus_io.rom_clken   = rom_clken_q;
    assign bus_io.busy        = busy_q;
    assign bus_io.pixel_valid = pix_valid_q;
    assign bus_io.pixel_color = pix_color_q;

endmodule

// File: tb/tb_tank_sprite_line_fetcher.sv
// Scoreboard bench: stimulus pushes expected ROM addresses and pixels, a negedge
// monitor pops and compares whatever the fetcher presents.
module tb_tank_sprite_line_fetcher;

    typedef struct {
        int         h;
        logic [7:0] c;
    } pix_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [9:0] h_d1 = '0;
    int vectors = 0;
    int errs = 0;
    int busy_cnt = 0;
    logic [11:0] addr_q[$];
    pix_t pix_q[$];

    tank_sprite_line_fetcher_if bus ();

    tank_sprite_line_fetcher dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    // Sprite ROM stand-in: data = address[7:0], one-cycle synchronous read.
    always @(posedge clk) begin
        if (bus.rom_clken) bus.rom_readdata <= bus.rom_address[7:0];
        h_d1 <= bus.hcount;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [11:0] ea;
        pix_t ep;
        if (bus.busy) busy_cnt++;
        if (bus.rom_clken) begin
            if (addr_q.size() == 0) begin
                vectors++;
                errs++;
                $display("FAIL rom_addr: got %0h, no fetch expected (t=%0t)", bus.rom_address,
                         $time);
            end else begin
                ea = addr_q.pop_front();
                check("rom_addr", 32'(bus.rom_address), 32'(ea));
            end
        end
        if (bus.pixel_valid) begin
            if (pix_q.size() == 0) begin
                vectors++;
                errs++;
                $display("FAIL pixel: got h=%0d color=%0h, none expected (t=%0t)", h_d1,
                         bus.pixel_color, $time);
            end else begin
                ep = pix_q.pop_front();
                check("pix_h", 32'(h_d1), 32'(ep.h));
                check("pix_color", 32'(bus.pixel_color), 32'(ep.c));
            end
        end else if (bus.pixel_color !== 8'h00) begin
            check("pix_color_idle", 32'(bus.pixel_color), 32'h0);
        end
    end

    function automatic logic [11:0] ref_addr(input int d, input int r, input int c);
        int row, col;
        case (d)
            0:       begin row = r;      col = c;      end
            1:       begin row = 63 - c; col = r;      end
            2:       begin row = 63 - r; col = 63 - c; end
            default: begin row = c;      col = 63 - r; end
        endcase
        return 12'(row * 64 + col);
    endfunction

    task automatic push_fetch(input int d, input int r, input int n);
        for (int c = 0; c < n; c++) addr_q.push_back(ref_addr(d, r, c));
    endtask

    task automatic push_pix(input int d, input int r, input int x);
        logic [11:0] a;
        pix_t p;
        for (int c = 0; c < 64; c++) begin
            a = ref_addr(d, r, c);
            p.h = x + c;
            p.c = a[7:0];
            if (p.h < 640 && p.c != 8'h00) pix_q.push_back(p);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rom_address"}, 32'(bus.rom_address), 32'h0);
        check({tag, "_rom_clken"}, 32'(bus.rom_clken), 32'h0);
        check({tag, "_busy"}, 32'(bus.busy), 32'h0);
        check({tag, "_pixel_valid"}, 32'(bus.pixel_valid), 32'h0);
        check({tag, "_pixel_color"}, 32'(bus.pixel_color), 32'h0);
    endtask

    // One 800-cycle line; optional line_start at 640, re-pulse (with new vcount) and reset.
    task automatic run_line(input int v, input bit pulse, input int abort_h, input int abort_v,
                            input int rst_h, input int exp_busy);
        int b0;
        b0 = busy_cnt;
        bus.vcount = 10'(v);
        for (int h = 0; h < 800; h++) begin
            @(posedge clk);
            #1;
            bus.hcount     = 10'(h);
            bus.line_start = (pulse && h == 640) || (h == abort_h);
            if (h == abort_h) bus.vcount = 10'(abort_v);
            if (h == rst_h) begin
                reset_n = 1'b0;
                #1;
                check_idle("rst_mid");
            end
            if (h == rst_h + 4) reset_n = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.line_start = 1'b0;
        @(negedge clk);
        check("busy_cycles", 32'(busy_cnt - b0), 32'(exp_busy));
        check("addr_left", 32'(addr_q.size()), 32'h0);
        check("pix_left", 32'(pix_q.size()), 32'h0);
        addr_q.delete();
        pix_q.delete();
    endtask

    initial begin
        bus.hcount     = '0;
        bus.vcount     = '0;
        bus.line_start = 1'b0;
        bus.tank_x     = 10'd100;
        bus.tank_y     = 10'd50;
        bus.tank_dir   = 2'd0;
        bus.tank_en    = 1'b1;
        #2;
        check_idle("reset");
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Frame latch (nl=0 outside sprite), then dir0 fetch of row 3 and row 4.
        run_line(524, 1, -1, 0, -1, 0);
        push_fetch(0, 3, 64);
        run_line(52, 1, -1, 0, -1, 65);
        push_pix(0, 3, 100);
        push_fetch(0, 4, 64);
        run_line(53, 1, -1, 0, -1, 65);
        push_pix(0, 4, 100);
        run_line(54, 0, -1, 0, -1, 0);

        // New dir must not take effect until the frame latch.
        bus.tank_dir = 2'd2;
        push_pix(0, 4, 100);
        run_line(524, 1, -1, 0, -1, 0);
        push_fetch(2, 0, 64);
        run_line(49, 1, -1, 0, -1, 65);
        push_pix(2, 0, 100);
        run_line(50, 0, -1, 0, -1, 0);

        // dir3 at x=600: right-edge clipping.
        bus.tank_dir = 2'd3;
        bus.tank_x   = 10'd600;
        push_pix(2, 0, 100);
        run_line(524, 1, -1, 0, -1, 0);
        push_fetch(3, 0, 64);
        run_line(49, 1, -1, 0, -1, 65);
        push_pix(3, 0, 600);
        run_line(50, 0, -1, 0, -1, 0);

        // Restart at c=30 with a different next line; only row 2 may ever be shown.
        push_pix(3, 0, 600);
        push_fetch(3, 1, 31);
        push_fetch(3, 2, 64);
        run_line(50, 1, 671, 51, -1, 96);
        push_pix(3, 2, 600);
        run_line(52, 0, -1, 0, -1, 0);

        // Sprite disabled for a frame: no ROM activity, no pixels.
        bus.tank_en = 1'b0;
        push_pix(3, 2, 600);
        run_line(524, 1, -1, 0, -1, 0);
        run_line(0, 1, -1, 0, -1, 0);
        run_line(1, 1, -1, 0, -1, 0);

        // tank_y=500: wrap to line 0 is outside the sprite.
        bus.tank_en  = 1'b1;
        bus.tank_y   = 10'd500;
        bus.tank_x   = 10'd100;
        bus.tank_dir = 2'd0;
        run_line(524, 1, -1, 0, -1, 0);
        run_line(0, 1, -1, 0, -1, 0);

        // Reset at c=20 of a fetch; nothing shown afterwards.
        bus.tank_y = 10'd50;
        run_line(524, 1, -1, 0, -1, 0);
        push_fetch(0, 3, 20);
        run_line(52, 1, -1, 0, 661, 20);
        run_line(53, 1, -1, 0, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
